sig_monitor: RTL and testbench

Synthesizable signature/halt monitor that sits on the writeback-stage store path of the 5-stage RV32IM pipeline. It replaces ad-hoc bench-side address snooping with a parametrised block that:
- captures stores to a signature address into a FIFO;
- detects a halt-address store;
- runs a cycle watchdog;
- drains the captured words over a valid/ready port to a bench file writer or UART.

---
 rtl/sig_monitor.sv | 174 +++++++++++++++++
 tb/tb_sig_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sig_monitor.sv
// ============================================================================
// sig_monitor: captures signature stores into a FIFO, detects the halt store,
// runs a cycle watchdog and drains captured words over a valid/ready port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sig_monitor #(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        DEPTH     = 16,
  parameter logic [ADDR_W-1:0]  SIG_ADDR  = 32'h0000_0F00,
  parameter logic [ADDR_W-1:0]  HALT_ADDR = 32'hCAFE_BEEF,
  parameter int unsigned        TIMEOUT   = 500000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     sig_valid,
  output logic [DATA_W-1:0]        sig_data,
  input  logic                     sig_ready,
  output logic [$clog2(DEPTH):0]   sig_count,
  output logic                     overflow,
  output logic                     halted,
  output logic                     timed_out,
  output logic                     done,
  output logic [31:0]              cycle_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [31:0]   LAST_CYCLE = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                sig_valid_q, sig_valid_d;
  logic                overflow_q, overflow_d;
  logic                halted_q, halted_d;
  logic                timed_out_q, timed_out_d;
  logic                done_q, done_d;
  logic [31:0]         cycle_q, cycle_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                sig_hit;
  logic                halt_hit;
  logic                push_req;
  logic                full;
  logic                pop;
  logic                push;

  assign sig_hit  = st_valid && (st_addr == SIG_ADDR);
  assign halt_hit = st_valid && (st_addr == HALT_ADDR);
  assign push_req = (state_q == ST_RUN) && sig_hit;
  assign full     = (count_q == CNT_FULL);
  assign pop      = sig_valid_q && sig_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    halted_d    = halted_q;
    timed_out_d = timed_out_q;
    done_d      = done_q;
    cycle_d     = cycle_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
    if (push_req && full && !pop) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (cycle_q != 32'hFFFF_FFFF) begin
          cycle_d = cycle_q + 32'd1;
        end
        // Halt takes priority over a watchdog expiry in the same cycle.
        if (halt_hit) begin
          halted_d = 1'b1;
          state_d  = ST_DRAIN;
        end else if (cycle_q == LAST_CYCLE) begin
          timed_out_d = 1'b1;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (count_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    sig_valid_d = (count_d != '0) && (state_d != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sig_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      halted_q    <= 1'b0;
      timed_out_q <= 1'b0;
      done_q      <= 1'b0;
      cycle_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sig_valid_q <= sig_valid_d;
      overflow_q  <= overflow_d;
      halted_q    <= halted_d;
      timed_out_q <= timed_out_d;
      done_q      <= done_d;
      cycle_q     <= cycle_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= st_data;
    end
  end

  assign sig_valid   = sig_valid_q;
  assign sig_data    = mem_q[rd_ptr_q];
  assign sig_count   = count_q;
  assign overflow    = overflow_q;
  assign halted      = halted_q;
  assign timed_out   = timed_out_q;
  assign done        = done_q;
  assign cycle_count = cycle_q;

endmodule

`default_nettype wire

// File: tb/tb_sig_monitor.sv
// ============================================================================
// tb_sig_monitor: directed self-checking bench for sig_monitor (DEPTH=4,
// TIMEOUT=10). Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sig_monitor;

  localparam logic [31:0] SIG  = 32'h0000_0F00;
  localparam logic [31:0] HALT = 32'hCAFE_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        sig_valid;
  logic [31:0] sig_data;
  logic        sig_ready;
  logic [2:0]  sig_count;
  logic        overflow;
  logic        halted;
  logic        timed_out;
  logic        done;
  logic [31:0] cycle_count;

  int errors = 0;
  int checks = 0;

  sig_monitor #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .DEPTH    (4),
    .SIG_ADDR (SIG),
    .HALT_ADDR(HALT),
    .TIMEOUT  (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .sig_valid  (sig_valid),
    .sig_data   (sig_data),
    .sig_ready  (sig_ready),
    .sig_count  (sig_count),
    .overflow   (overflow),
    .halted     (halted),
    .timed_out  (timed_out),
    .done       (done),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    st_valid = 1'b1;
    st_addr  = addr;
    st_data  = data;
    step();
    st_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    sig_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sig_valid !== 1'b0) begin errors++; $display("FAIL rst_sig_valid got=%b exp=0", sig_valid); end
    checks++; if (sig_count !== 3'd0) begin errors++; $display("FAIL rst_sig_count got=%0d exp=0", sig_count); end
    checks++; if ({overflow, halted, timed_out, done} !== 4'b0000) begin errors++; $display("FAIL rst_flags got=%b exp=0000", {overflow, halted, timed_out, done}); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL rst_cycle_count got=%0d exp=0", cycle_count); end
  endtask

  task automatic test_capture_order();
    logic [31:0] words [3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    do_reset();
    sig_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      store(SIG, words[i]);
      checks++; if (sig_valid !== 1'b1 || sig_data !== words[i]) begin errors++; $display("FAIL cap_head%0d got=%b/%h exp=1/%h", i, sig_valid, sig_data, words[i]); end
      checks++; if (sig_count !== 3'd1) begin errors++; $display("FAIL cap_count%0d got=%0d exp=1", i, sig_count); end
    end
    step();
    checks++; if (sig_valid !== 1'b0 || sig_count !== 3'd0) begin errors++; $display("FAIL cap_empty got=%b/%0d exp=0/0", sig_valid, sig_count); end
    checks++; if (cycle_count !== 32'd4) begin errors++; $display("FAIL cap_cycles got=%0d exp=4", cycle_count); end
    sig_ready = 1'b0;
  endtask

  task automatic test_halt_drain();
    do_reset();
    store(SIG, 32'hA1);
    store(SIG, 32'hA2);
    store(SIG, 32'hA3);
    checks++; if (sig_count !== 3'd3 || sig_data !== 32'hA1) begin errors++; $display("FAIL hd_fill got=%0d/%h exp=3/a1", sig_count, sig_data); end
    store(HALT, 32'h0);
    checks++; if (halted !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL hd_halted got=%b/%b exp=1/0", halted, done); end
    checks++; if (sig_count !== 3'd3) begin errors++; $display("FAIL hd_halt_not_captured got=%0d exp=3", sig_count); end
    store(SIG, 32'h99);
    checks++; if (sig_count !== 3'd3 || overflow !== 1'b0) begin errors++; $display("FAIL hd_ignored got=%0d/%b exp=3/0", sig_count, overflow); end
    checks++; if (cycle_count !== 32'd4) begin errors++; $display("FAIL hd_frozen got=%0d exp=4", cycle_count); end
    sig_ready = 1'b1;
    step();
    checks++; if (sig_data !== 32'hA2 || sig_count !== 3'd2) begin errors++; $display("FAIL hd_pop1 got=%h/%0d exp=a2/2", sig_data, sig_count); end
    step();
    checks++; if (sig_data !== 32'hA3 || sig_count !== 3'd1) begin errors++; $display("FAIL hd_pop2 got=%h/%0d exp=a3/1", sig_data, sig_count); end
    step();
    checks++; if (sig_valid !== 1'b0 || sig_count !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL hd_empty got=%b/%0d/%b exp=0/0/0", sig_valid, sig_count, done); end
    step();
    checks++; if (done !== 1'b1 || timed_out !== 1'b0) begin errors++; $display("FAIL hd_done got=%b/%b exp=1/0", done, timed_out); end
    sig_ready = 1'b0;
    step();
    checks++; if (done !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL hd_sticky got=%b/%b exp=1/1", done, halted); end
  endtask

  task automatic test_halt_empty();
    do_reset();
    store(HALT, 32'h5);
    checks++; if (halted !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL he_halt got=%b/%b exp=1/0", halted, done); end
    step();
    checks++; if (done !== 1'b1 || sig_valid !== 1'b0) begin errors++; $display("FAIL he_done got=%b/%b exp=1/0", done, sig_valid); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) store(SIG, 32'hA0 + 32'(i));
    checks++; if (sig_count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL fo_full got=%0d/%b exp=4/0", sig_count, overflow); end
    store(SIG, 32'hA4);
    checks++; if (sig_count !== 3'd4 || overflow !== 1'b1 || sig_data !== 32'hA0) begin errors++; $display("FAIL fo_drop got=%0d/%b/%h exp=4/1/a0", sig_count, overflow, sig_data); end
    sig_ready = 1'b1;
    store(SIG, 32'hA5);
    checks++; if (sig_count !== 3'd4 || sig_data !== 32'hA1 || overflow !== 1'b1) begin errors++; $display("FAIL fo_push_pop got=%0d/%h/%b exp=4/a1/1", sig_count, sig_data, overflow); end
    step();
    checks++; if (sig_data !== 32'hA2) begin errors++; $display("FAIL fo_d2 got=%h exp=a2", sig_data); end
    step();
    checks++; if (sig_data !== 32'hA3) begin errors++; $display("FAIL fo_d3 got=%h exp=a3", sig_data); end
    step();
    checks++; if (sig_data !== 32'hA5 || sig_count !== 3'd1) begin errors++; $display("FAIL fo_d5 got=%h/%0d exp=a5/1", sig_data, sig_count); end
    step();
    checks++; if (sig_valid !== 1'b0 || sig_count !== 3'd0) begin errors++; $display("FAIL fo_empty got=%b/%0d exp=0/0", sig_valid, sig_count); end
    sig_ready = 1'b0;
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < 9; i++) step();
    checks++; if (timed_out !== 1'b0 || cycle_count !== 32'd9) begin errors++; $display("FAIL wd_pre got=%b/%0d exp=0/9", timed_out, cycle_count); end
    step();
    checks++; if (timed_out !== 1'b1 || cycle_count !== 32'd10 || done !== 1'b0) begin errors++; $display("FAIL wd_fire got=%b/%0d/%b exp=1/10/0", timed_out, cycle_count, done); end
    step();
    checks++; if (done !== 1'b1 || cycle_count !== 32'd10) begin errors++; $display("FAIL wd_done got=%b/%0d exp=1/10", done, cycle_count); end
    step();
    checks++; if (timed_out !== 1'b1 || cycle_count !== 32'd10 || halted !== 1'b0) begin errors++; $display("FAIL wd_sticky got=%b/%0d/%b exp=1/10/0", timed_out, cycle_count, halted); end
    do_reset();
    for (int i = 0; i < 9; i++) step();
    store(HALT, 32'h0);
    checks++; if (halted !== 1'b1 || timed_out !== 1'b0 || cycle_count !== 32'd10) begin errors++; $display("FAIL wd_halt_wins got=%b/%b/%0d exp=1/0/10", halted, timed_out, cycle_count); end
    step();
    checks++; if (done !== 1'b1 || timed_out !== 1'b0) begin errors++; $display("FAIL wd_halt_done got=%b/%b exp=1/0", done, timed_out); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    for (int i = 0; i < 5; i++) store(SIG, 32'hB0 + 32'(i));
    sig_ready = 1'b1;
    step();
    step();
    sig_ready = 1'b0;
    checks++; if (sig_count !== 3'd2 || overflow !== 1'b1) begin errors++; $display("FAIL rm_pre got=%0d/%b exp=2/1", sig_count, overflow); end
    do_reset();
    checks++; if ({sig_valid, overflow, halted, timed_out, done} !== 5'b0 || sig_count !== 3'd0 || cycle_count !== 32'd0) begin errors++; $display("FAIL rm_cleared got=%b/%0d/%0d exp=00000/0/0", {sig_valid, overflow, halted, timed_out, done}, sig_count, cycle_count); end
    store(SIG, 32'h5A);
    checks++; if (sig_valid !== 1'b1 || sig_data !== 32'h5A || sig_count !== 3'd1) begin errors++; $display("FAIL rm_capture got=%b/%h/%0d exp=1/5a/1", sig_valid, sig_data, sig_count); end
    checks++; if (cycle_count !== 32'd1 || done !== 1'b0) begin errors++; $display("FAIL rm_run got=%0d/%b exp=1/0", cycle_count, done); end
  endtask

  task automatic test_nonmatch();
    do_reset();
    store(32'h0000_0F04, 32'h77);
    checks++; if (sig_count !== 3'd0 || sig_valid !== 1'b0) begin errors++; $display("FAIL nm_addr got=%0d/%b exp=0/0", sig_count, sig_valid); end
    st_valid = 1'b0; st_addr = SIG; st_data = 32'h88;
    step();
    checks++; if (sig_count !== 3'd0 || sig_valid !== 1'b0) begin errors++; $display("FAIL nm_invalid got=%0d/%b exp=0/0", sig_count, sig_valid); end
    st_addr = HALT;
    step();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL nm_halt_invalid got=%b exp=0", halted); end
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; sig_ready = 1'b0;
    test_reset();
    test_capture_order();
    test_halt_drain();
    test_halt_empty();
    test_full_overflow();
    test_watchdog();
    test_reset_midrun();
    test_nonmatch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
